// File: rtl/serial_deserializer.sv
// LSB-first serial-to-parallel receiver with a one-entry valid/ready output buffer.
// Optional even-parity check per word when DESER_PARITY_CHECK_EN is defined.
module serial_deserializer #(
  parameter int DATA_WIDTH = 16,
  parameter int CNT_WIDTH  = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_in,
  input  logic                  s_valid,
  input  logic                  s_start,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  overrun,
  output logic                  frame_err,
  input  logic                  clr_flags
`ifdef DESER_PARITY_CHECK_EN
  ,
  output logic                  parity_err
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    PARITY
  } state_t;

  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_shreg;
  logic [CNT_WIDTH-1:0]  r_cnt;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_valid;
  logic                  r_busy;
  logic                  r_over;
  logic                  r_ferr;

  state_t                w_nstate;
  logic [DATA_WIDTH-1:0] w_shreg;
  logic [DATA_WIDTH-1:0] w_word;
  logic [CNT_WIDTH-1:0]  w_cnt;
  logic                  w_shift;
  logic                  w_commit;
  logic                  w_ferr;
  logic                  w_last;
  logic                  w_set_over;
`ifdef DESER_PARITY_CHECK_EN
  logic                  r_perr;
  logic                  w_perr;
`endif

  assign w_shreg = {s_in, r_shreg[DATA_WIDTH-1:1]};
  assign w_last  = (r_cnt == CNT_WIDTH'(DATA_WIDTH - 1));

  always_comb begin
    w_nstate = r_state;
    w_word   = w_shreg;
    w_cnt    = r_cnt;
    w_shift  = 1'b0;
    w_commit = 1'b0;
    w_ferr   = 1'b0;
`ifdef DESER_PARITY_CHECK_EN
    w_perr   = 1'b0;
`endif
    if (s_valid) begin
      unique case (r_state)
        IDLE: begin
          if (s_start) begin
            w_shift  = 1'b1;
            w_cnt    = CNT_WIDTH'(1);
            w_nstate = SHIFT;
          end
        end
        SHIFT: begin
          w_shift = 1'b1;
          if (s_start) begin
            w_ferr = 1'b1;
            w_cnt  = CNT_WIDTH'(1);
          end else begin
            w_cnt = r_cnt + CNT_WIDTH'(1);
            if (w_last) begin
`ifdef DESER_PARITY_CHECK_EN
              w_nstate = PARITY;
`else
              w_commit = 1'b1;
              w_nstate = IDLE;
`endif
            end
          end
        end
`ifdef DESER_PARITY_CHECK_EN
        PARITY: begin
          if (s_start) begin
            w_ferr   = 1'b1;
            w_shift  = 1'b1;
            w_cnt    = CNT_WIDTH'(1);
            w_nstate = SHIFT;
          end else begin
            // Parity bit is not shifted in; the word is already complete.
            w_word   = r_shreg;
            w_commit = 1'b1;
            w_perr   = ^{r_shreg, s_in};
            w_nstate = IDLE;
          end
        end
`endif
        default: w_nstate = IDLE;
      endcase
    end
  end

  assign w_set_over = w_commit && r_valid && !out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_shreg <= '0;
      r_cnt   <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_over  <= 1'b0;
      r_ferr  <= 1'b0;
`ifdef DESER_PARITY_CHECK_EN
      r_perr  <= 1'b0;
`endif
    end else begin
      r_state <= w_nstate;
      r_busy  <= (w_nstate != IDLE);
      r_ferr  <= w_ferr;
      r_cnt   <= w_cnt;
      if (w_shift) r_shreg <= w_shreg;
      if (w_commit && !w_set_over) begin
        r_data  <= w_word;
        r_valid <= 1'b1;
      end else if (r_valid && out_ready) begin
        r_valid <= 1'b0;
      end
      if (w_set_over) r_over <= 1'b1;
      else if (clr_flags) r_over <= 1'b0;
`ifdef DESER_PARITY_CHECK_EN
      if (w_commit && w_perr) r_perr <= 1'b1;
      else if (clr_flags) r_perr <= 1'b0;
`endif
    end
  end

  assign out_data  = r_data;
  assign out_valid = r_valid;
  assign busy      = r_busy;
  assign overrun   = r_over;
  assign frame_err = r_ferr;
`ifdef DESER_PARITY_CHECK_EN
  assign parity_err = r_perr;
`endif

endmodule

// File: tb/tb_serial_deserializer.sv
// Bench for serial_deserializer: frame-level reference model checked every cycle,
// plus directed literal checks.
module tb_serial_deserializer;

  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          s_in, s_valid, s_start;
  logic [DW-1:0] out_data;
  logic          out_valid, out_ready;
  logic          busy, overrun, frame_err, clr_flags;
`ifdef DESER_PARITY_CHECK_EN
  logic          parity_err;
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  serial_deserializer #(.DATA_WIDTH(DW), .CNT_WIDTH(5)) dut (
    .clk(clk), .rst(rst), .s_in(s_in), .s_valid(s_valid), .s_start(s_start),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .overrun(overrun), .frame_err(frame_err),
    .clr_flags(clr_flags)
`ifdef DESER_PARITY_CHECK_EN
    , .parity_err(parity_err)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;
  int ferr_seen = 0;

  // Reference model: frame collected as a bit count and an arithmetic accumulator
  int unsigned m_acc;
  int          m_n;
  bit          m_active, m_pwait;
  bit          m_valid, m_over, m_ferr, m_perr;
  int unsigned m_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic m_commit(input int unsigned w, input bit rdy);
    if (!m_valid || rdy) begin
      m_data  = w;
      m_valid = 1'b1;
    end else begin
      m_over = 1'b1;
    end
  endtask

  always @(posedge clk) begin
    bit xfer, over_was, com;
    if (rst) begin
      m_acc = 0; m_n = 0; m_active = 0; m_pwait = 0;
      m_valid = 0; m_over = 0; m_ferr = 0; m_perr = 0; m_data = 0;
    end else begin
      xfer     = m_valid && out_ready;
      over_was = m_over;
      com      = 1'b0;
      m_ferr   = 1'b0;
      if (clr_flags) begin
        m_over = 1'b0;
        m_perr = 1'b0;
      end
      if (s_valid) begin
        if (s_start) begin
          if (m_active || m_pwait) m_ferr = 1'b1;
          m_acc = int'(s_in); m_n = 1; m_active = 1; m_pwait = 0;
        end else if (m_pwait) begin
          m_pwait = 0;
          if (($countones(m_acc) + int'(s_in)) % 2 != 0) m_perr = 1'b1;
          com = 1'b1;
          m_commit(m_acc, out_ready);
        end else if (m_active) begin
          m_acc = m_acc + (int'(s_in) << m_n);
          m_n++;
          if (m_n == DW) begin
            m_active = 0;
            if (PAR) m_pwait = 1;
            else begin
              com = 1'b1;
              m_commit(m_acc, out_ready);
            end
          end
        end
      end
      if (!com && xfer) m_valid = 1'b0;
      if (com && !m_valid) m_valid = 1'b0;
      if (!clr_flags && over_was) m_over = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("valid", 32'(out_valid), 32'(m_valid));
      if (m_valid) chk("data", 32'(out_data), m_data);
      chk("busy", 32'(busy), 32'(m_active || m_pwait));
      chk("overrun", 32'(overrun), 32'(m_over));
      chk("frame_err", 32'(frame_err), 32'(m_ferr));
`ifdef DESER_PARITY_CHECK_EN
      chk("parity_err", 32'(parity_err), 32'(m_perr));
`endif
      if (frame_err === 1'b1) ferr_seen++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input logic st);
    s_in = b; s_start = st; s_valid = 1'b1;
    tick();
    s_valid = 1'b0; s_start = 1'b0; s_in = 1'b0;
  endtask

  task automatic send_word(input logic [DW-1:0] w, input bit gaps, input bit par_bad);
    for (int i = 0; i < DW; i++) begin
      if (gaps && i > 0 && $urandom_range(0, 2) == 0) begin
        s_in = 1'($urandom);
        tick();
        chk("busy_gap", 32'(busy), 32'd1);
      end
      send_bit(w[i], i == 0);
    end
    if (PAR) send_bit((^w) ^ par_bad, 1'b0);
  endtask

  initial begin
    logic [DW-1:0] part;
    rst = 1'b1; s_in = 1'b0; s_valid = 1'b0; s_start = 1'b0;
    out_ready = 1'b0; clr_flags = 1'b0;
    // 1: reset with random inputs
    for (int i = 0; i < 2; i++) begin
      s_in = 1'($urandom); s_valid = 1'($urandom); s_start = 1'($urandom);
      out_ready = 1'($urandom); clr_flags = 1'($urandom);
      tick();
      cmp_en = 1'b1;
    end
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_over", 32'(overrun), 32'd0);
    chk("rst_ferr", 32'(frame_err), 32'd0);
    rst = 1'b0; s_valid = 1'b0; s_start = 1'b0; clr_flags = 1'b0;
    out_ready = 1'b1;
    tick();
    // stray bits without s_start are dropped in IDLE
    send_bit(1'b1, 1'b0);
    chk("drop_busy", 32'(busy), 32'd0);

    // 2: single word with ready consumer
    send_word(16'hA5C3, 1'b0, 1'b0);
    chk("t2_valid", 32'(out_valid), 32'd1);
    chk("t2_data", 32'(out_data), 32'hA5C3);
    tick();
    chk("t2_clear", 32'(out_valid), 32'd0);

    // 3: back-to-back with stalled consumer
    out_ready = 1'b0;
    send_word(16'h1111, 1'b0, 1'b0);
    send_word(16'h2222, 1'b0, 1'b0);
    chk("t3_valid", 32'(out_valid), 32'd1);
    chk("t3_data", 32'(out_data), 32'h1111);
    chk("t3_over", 32'(overrun), 32'd1);
    clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
    chk("t3_clr", 32'(overrun), 32'd0);
    out_ready = 1'b1;
    tick();
    chk("t3_drain", 32'(out_valid), 32'd0);

    // 4: abort after 7 bits, restart with 0x1234
    ferr_seen = 0;
    part = 16'h005A;
    for (int i = 0; i < 7; i++) send_bit(part[i], i == 0);
    send_word(16'h1234, 1'b0, 1'b0);
    chk("t4_data", 32'(out_data), 32'h1234);
    chk("t4_valid", 32'(out_valid), 32'd1);
    tick();
    chk("t4_ferr_cnt", 32'(ferr_seen), 32'd1);

    // 5: gaps inside 0xFFFF
    send_word(16'hFFFF, 1'b1, 1'b0);
    chk("t5_data", 32'(out_data), 32'hFFFF);
    chk("t5_valid", 32'(out_valid), 32'd1);
    tick();

`ifdef DESER_PARITY_CHECK_EN
    // 6: parity good then bad
    clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
    send_word(16'h0001, 1'b0, 1'b0);
    chk("t6_perr_ok", 32'(parity_err), 32'd0);
    chk("t6_data_ok", 32'(out_data), 32'h0001);
    tick();
    send_word(16'h0001, 1'b0, 1'b1);
    chk("t6_perr_bad", 32'(parity_err), 32'd1);
    chk("t6_data_bad", 32'(out_data), 32'h0001);
    tick();
`endif

    // reset mid-frame discards partial word
    for (int i = 0; i < 5; i++) send_bit(1'b1, i == 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_data", 32'(out_data), 32'd0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
